// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences accumulator over N-sample blocks,
// with peak |x| tracking and a backpressured result handshake.
module sad_accumulator #(
  parameter int DW    = 16,
  parameter int N     = 8,
  parameter int ACC_W = 19,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sad,
  output logic [DW-1:0]    out_peak
);

  typedef enum logic {
    S_ACC,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [DW-1:0]      r_peak;
  logic [DW-1:0]      w_peak_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic [ACC_W-1:0]   r_out_sad;
  logic [ACC_W-1:0]   w_out_sad_nxt;
  logic [DW-1:0]      r_out_peak;
  logic [DW-1:0]      w_out_peak_nxt;

  logic               w_accept;
  logic               w_last;
  logic [DW-1:0]      w_abs;
  logic [ACC_W-1:0]   w_sum;
  logic [DW-1:0]      w_max;

  assign in_ready  = (r_state == S_ACC) && !clear;
  assign out_valid = r_out_valid;
  assign out_sad   = r_out_sad;
  assign out_peak  = r_out_peak;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_count == CW'(N - 1));

  // Unsigned DW-bit magnitude: the most negative input maps to 2^(DW-1).
  assign w_abs = in_diff[DW-1] ? (~in_diff + DW'(1)) : in_diff;
  assign w_sum = r_acc + ACC_W'(w_abs);
  assign w_max = (w_abs > r_peak) ? w_abs : r_peak;

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_acc_nxt       = r_acc;
    w_peak_nxt      = r_peak;
    w_out_valid_nxt = r_out_valid;
    w_out_sad_nxt   = r_out_sad;
    w_out_peak_nxt  = r_out_peak;
    if (clear) begin
      w_state_nxt     = S_ACC;
      w_count_nxt     = '0;
      w_acc_nxt       = '0;
      w_peak_nxt      = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ACC: begin
          if (w_accept && w_last) begin
            w_out_sad_nxt   = w_sum;
            w_out_peak_nxt  = w_max;
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_peak_nxt      = '0;
            w_count_nxt     = '0;
            w_state_nxt     = S_HOLD;
          end else if (w_accept) begin
            w_acc_nxt   = w_sum;
            w_peak_nxt  = w_max;
            w_count_nxt = r_count + CW'(1);
          end
        end
        S_HOLD: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_ACC;
          end
        end
        default: w_state_nxt = S_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_count     <= '0;
      r_acc       <= '0;
      r_peak      <= '0;
      r_out_valid <= 1'b0;
      r_out_sad   <= '0;
      r_out_peak  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_acc       <= w_acc_nxt;
      r_peak      <= w_peak_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sad   <= w_out_sad_nxt;
      r_out_peak  <= w_out_peak_nxt;
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// Scoreboard bench for sad_accumulator: expected block results
// are queued as samples are driven and compared on handshake.
module tb_sad_accumulator;

  localparam int DW    = 16;
  localparam int N     = 8;
  localparam int ACC_W = 19;
  localparam int CW    = 3;

  typedef struct {
    logic [ACC_W-1:0] sad;
    logic [DW-1:0]    peak;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_diff;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sad;
  logic [DW-1:0]    out_peak;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   n_acc    = 0;

  sad_accumulator #(
    .DW(DW), .N(N), .ACC_W(ACC_W), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_diff(in_diff),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sad(out_sad),
    .out_peak(out_peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (in_valid && in_ready) n_acc++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_pop++;
        chk("sad", 32'(out_sad), 32'(e.sad));
        chk("peak", 32'(out_peak), 32'(e.peak));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_diff  = d;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_diff  = 'x;
  endtask

  task automatic block(input logic [DW-1:0] d[N],
                       input bit push,
                       input bit gaps);
    exp_t e;
    int   s;
    int   p;
    s = 0;
    p = 0;
    for (int i = 0; i < N; i++) begin
      int v;
      v = int'($signed(d[i]));
      if (v < 0) v = -v;
      s += v;
      if (v > p) p = v;
    end
    e.sad  = ACC_W'(s);
    e.peak = DW'(p);
    if (push) begin
      q.push_back(e);
      n_push++;
    end
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send(d[i]);
    end
  endtask

  task automatic fill(output logic [DW-1:0] d[N],
                      input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) d[i] = v;
  endtask

  initial begin
    logic [DW-1:0] d[N];
    int            a0;
    int            t;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_diff   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_sad", 32'(out_sad), 0);
    chk("rst_out_peak", 32'(out_peak), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    d[0] = 16'd1;  d[1] = -16'sd2;
    d[2] = 16'd3;  d[3] = -16'sd4;
    d[4] = 16'd5;  d[5] = -16'sd6;
    d[6] = 16'd7;  d[7] = -16'sd8;
    block(d, 1, 0);
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("hold_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_diff  = 16'd99;
    a0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_sad", 32'(out_sad), 36);
      chk("hold_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    chk("hold_no_accept", 32'(n_acc - a0), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_out_valid", 32'(out_valid), 0);
    chk("hs_in_ready", 32'(in_ready), 1);

    fill(d, 16'd10);
    block(d, 1, 0);
    fill(d, 16'h8000);
    block(d, 1, 0);
    fill(d, -16'sd3);
    block(d, 1, 1);

    for (int i = 0; i < 5; i++) send(16'd100);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_diff  = 16'd100;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    fill(d, 16'd1);
    block(d, 1, 0);

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fill(d, 16'd2);
    block(d, 0, 0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    block(d, 1, 0);

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("sb_drain", 32'(q.size()), 0);
    chk("n_results", 32'(n_pop), 32'(n_push));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
